if_fetch_stage: RTL
===================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage feeding the IF/ID boundary in front of the load-use hazard detector.
//  Owns the PC and a req/ack handshake to the instruction cache.
//  Holds or bubbles the IF/ID register under hazard stall, data-cache stall and branch flush.
//  Outputs ifid_* drive the ID stage, whose rs1/rs2 fields return to the hazard detector.
// PARAMETERS
//  RESET_PC   32'h0000_0000  fetch address after reset
//  NOP_INSTR  32'h0000_0013  instruction word presented while ifid_valid_o=0 (addi x0,x0,0)
// PORTS
//  clk_i         in   1   single clock, all state on rising edge
//  rst_i         in   1   asynchronous, active-low reset
//  pc_write_i    in   1   hazard PCWrite; 0 blocks issue of a new fetch
//  stall_i       in   1   hazard Stall; 1 holds IF/ID register
//  mem_stall_i   in   1   data-cache miss; freezes PC, IF/ID, flush handling
//  flush_i       in   1   branch taken in ID; redirect to br_target_i
//  br_target_i   in   32  redirect address, valid with flush_i
//  imem_req_o    out  1   fetch request; held with stable addr until ack
//  imem_addr_o   out  32  fetch address (word aligned)
//  imem_ack_i    in   1   icache data valid; may assert in same cycle as req
//  imem_rdata_i  in   32  instruction word, valid with ack
//  ifid_valid_o  out  1   IF/ID holds a real instruction
//  ifid_pc_o     out  32  PC of IF/ID instruction
//  ifid_instr_o  out  32  IF/ID instruction (NOP_INSTR when invalid)
// BEHAVIOUR
//  Reset (rst_i=0, any time): pc=RESET_PC, state=IDLE, buffer empty, imem_req_o=0,
//   ifid_valid_o=0, ifid_pc_o=0, ifid_instr_o=NOP_INSTR; any outstanding fetch is abandoned.
//  States: IDLE (no request), WAIT (request live, data wanted), KILL (request live, data discarded).
//  imem_req_o = (state!=IDLE); imem_addr_o = registered fetch address.
//  Addr must not change while req=1 and ack=0.
//  Hold terms: ifid_hold = stall_i | mem_stall_i; can_issue = pc_write_i & ~mem_stall_i & buffer empty.
//  IDLE: can_issue -> WAIT with addr=pc; else stay.
//  WAIT, ack=1: word is "captured"; pc<=pc+4.
//   If !ifid_hold, word goes straight to IF/ID; else to one-entry skid buffer.
//   Next state WAIT (addr=pc+4) if can_issue after capture, else IDLE.
//   Zero-wait icache therefore sustains 1 instr/cycle.
//  WAIT, ack=0: stay.
//  flush_i=1 and mem_stall_i=0 (priority over stall_i and over capture):
//   pc<=br_target_i; buffer cleared; IF/ID <= bubble.
//   WAIT with ack=0 -> KILL. WAIT with ack=1 -> word dropped; next WAIT at br_target_i (if pc_write_i) else IDLE.
//   KILL with flush again -> update pc, stay KILL.
//  KILL: on ack, drop word -> WAIT at pc if can_issue, else IDLE.
//  IF/ID update when !ifid_hold and no flush: buffer if non-empty (buffer empties),
//   else fresh captured word, else bubble (valid=0, NOP_INSTR, pc unchanged).
//  ifid_hold=1: IF/ID unchanged; ack in WAIT with buffer empty still captured into buffer.
//  mem_stall_i=1: flush_i ignored (ID frozen, re-presents next cycle); handshake still completes into buffer.
//  Buffer full and ifid_hold: no issue (can_issue=0); never overflows.
//  PC arithmetic 32-bit, wraps 32'hFFFF_FFFC -> 0; br_target_i[1:0] ignored (forced 0).
// STRUCTURE
//  cpu_pkg: NOP_INSTR, RESET_PC defaults, fetch state encoding (IDLE/WAIT/KILL).
//  Sub-module fetch_skid_buf: one-entry {pc,instr} buffer with load/drain/clear and valid flag.
//  Top: PC register, FSM, IF/ID register, issue/hold logic.
// TESTING
//  1 Reset, ack tied 1, no stalls -> ifid_pc_o 0,4,8,C on consecutive cycles, valid=1 from cycle 2.
//  2 stall_i=1 & pc_write_i=0 for 1 cycle at pc=8 -> IF/ID holds PC 4 one extra cycle, buffer holds 8,
//    PC 8 in IF/ID next, no instr lost or duplicated.
//  3 ack delayed 3 cycles -> req/addr stable throughout, IF/ID bubbles (valid=0, 0x13) until ack.
//  4 flush_i with br_target_i=0x40 while WAIT ack=0 -> KILL; late word dropped; next valid IF/ID pc=0x40.
//  5 mem_stall_i=1 for 4 cycles with flush_i=1 -> no redirect, IF/ID frozen;
//    after release flush takes effect, next valid pc=target.
//  6 rst_i low mid-WAIT -> outputs to reset values immediately (async), first fetch after release at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-path definitions: reset defaults, fetch FSM encoding, IF/ID entry type.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;  // addi x0,x0,0

  // Fetch FSM: IDLE = no request, WAIT = request live and wanted, KILL = request live but stale.
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StKill = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Sequential fetch address; wraps naturally at 2^32.
  function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instr} skid buffer that parks a fetched word while IF/ID is held.
module fetch_skid_buf
  import cpu_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         drain_i,
  input  logic         clear_i,
  input  fetch_entry_t data_i,
  output logic         valid_o,
  output fetch_entry_t data_o
);

  logic         valid_q;
  fetch_entry_t data_q;

  // Clear (branch flush) wins over load; load and drain never coincide.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (clear_i) begin
        valid_q <= 1'b0;
      end else if (load_i) begin
        valid_q <= 1'b1;
        data_q  <= data_i;
      end else if (drain_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, icache req/ack handshake, and the IF/ID pipeline register
// with hold (hazard / dcache stall) and bubble (branch flush) control.
module if_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pc_write_i,
  input  logic        stall_i,
  input  logic        mem_stall_i,
  input  logic        flush_i,
  input  logic [31:0] br_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_instr_o
);

  logic [1:0]   state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic         ifid_valid_q, ifid_valid_d;
  logic [31:0]  ifid_pc_q, ifid_pc_d;
  logic [31:0]  ifid_instr_q, ifid_instr_d;

  logic         buf_valid, buf_load, buf_drain, buf_clear, buf_after;
  fetch_entry_t buf_data, cap_entry;

  logic         ifid_hold, flush_eff, can_issue, capture, issue_after_capture;
  logic [31:0]  redirect_pc, pc_inc;
  logic         unused_tgt_lsb;

  assign ifid_hold   = stall_i | mem_stall_i;
  // ID is frozen during a dcache stall, so its branch decision is re-presented later.
  assign flush_eff   = flush_i & ~mem_stall_i;
  assign can_issue   = pc_write_i & ~mem_stall_i & ~buf_valid;
  assign capture     = (state_q == StWait) & imem_ack_i;
  assign redirect_pc = {br_target_i[31:2], 2'b00};
  assign pc_inc      = next_word_addr(pc_q);
  assign cap_entry   = '{pc: addr_q, instr: imem_rdata_i};

  assign unused_tgt_lsb = ^br_target_i[1:0];

  fetch_skid_buf u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (buf_load),
    .drain_i (buf_drain),
    .clear_i (buf_clear),
    .data_i  (cap_entry),
    .valid_o (buf_valid),
    .data_o  (buf_data)
  );

  // IF/ID register and skid buffer steering: flush bubbles, hold freezes, else advance.
  always_comb begin
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    buf_load     = 1'b0;
    buf_drain    = 1'b0;
    buf_clear    = 1'b0;
    if (flush_eff) begin
      buf_clear    = 1'b1;
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
    end else if (!ifid_hold) begin
      if (buf_valid) begin
        buf_drain    = 1'b1;
        ifid_valid_d = 1'b1;
        ifid_pc_d    = buf_data.pc;
        ifid_instr_d = buf_data.instr;
      end else if (capture) begin
        ifid_valid_d = 1'b1;
        ifid_pc_d    = cap_entry.pc;
        ifid_instr_d = cap_entry.instr;
      end else begin
        ifid_valid_d = 1'b0;
        ifid_instr_d = NOP_INSTR;
      end
    end else if (capture) begin
      // WAIT is only entered with an empty buffer, so this never overwrites a parked word.
      buf_load = 1'b1;
    end
  end

  // Buffer occupancy as seen after this cycle's load/drain decides back-to-back issue.
  assign buf_after           = (buf_valid & ~buf_drain) | buf_load;
  assign issue_after_capture = pc_write_i & ~mem_stall_i & ~buf_after;

  // Fetch FSM and PC: flush redirects and retires/abandons the live request.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    if (flush_eff) begin
      pc_d = redirect_pc;
      unique case (state_q)
        StIdle: begin
          if (pc_write_i) begin
            state_d = StWait;
            addr_d  = redirect_pc;
          end
        end
        StWait, StKill: begin
          if (imem_ack_i) begin
            if (pc_write_i) begin
              state_d = StWait;
              addr_d  = redirect_pc;
            end else begin
              state_d = StIdle;
            end
          end else begin
            state_d = StKill;
          end
        end
        default: state_d = StIdle;
      endcase
    end else begin
      unique case (state_q)
        StIdle: begin
          if (can_issue) begin
            state_d = StWait;
            addr_d  = pc_q;
          end
        end
        StWait: begin
          if (imem_ack_i) begin
            pc_d = pc_inc;
            if (issue_after_capture) begin
              state_d = StWait;
              addr_d  = pc_inc;
            end else begin
              state_d = StIdle;
            end
          end
        end
        StKill: begin
          if (imem_ack_i) begin
            if (can_issue) begin
              state_d = StWait;
              addr_d  = pc_q;
            end else begin
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers; reset abandons any outstanding fetch.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= 32'h0;
      ifid_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
    end
  end

  assign imem_req_o   = (state_q != StIdle);
  assign imem_addr_o  = addr_q;
  assign ifid_valid_o = ifid_valid_q;
  assign ifid_pc_o    = ifid_pc_q;
  assign ifid_instr_o = ifid_instr_q;

endmodule
